// File: rtl/alu_vec_sequencer_if.sv
// Bundle of the command, register-file, ALU and write-back signals seen by
// the vector ALU sequencer. The sequencer connects through the slave modport.
// The surrounding core, or a testbench, connects through the master modport.
interface alu_vec_sequencer_if #(
    parameter int NUM_ELEM = 8,
    parameter int IDXW     = 3,
    parameter int DW       = 32
);
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [2:0]          cmd_op_i;
    logic [IDXW:0]       cmd_vl_i;
    logic                rd_en_o;
    logic [IDXW-1:0]     rd_idx_o;
    logic [DW-1:0]       rd_data1_i;
    logic [DW-1:0]       rd_data2_i;
    logic [DW-1:0]       alu_data1_o;
    logic [DW-1:0]       alu_data2_o;
    logic [2:0]          alu_ctrl_o;
    logic [DW-1:0]       alu_result_i;
    logic                alu_zero_i;
    logic                wb_valid_o;
    logic                wb_ready_i;
    logic [IDXW-1:0]     wb_idx_o;
    logic [DW-1:0]       wb_data_o;
    logic                done_o;
    logic [NUM_ELEM-1:0] zero_mask_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_vl_i, rd_data1_i, rd_data2_i,
               alu_result_i, alu_zero_i, wb_ready_i,
        output cmd_ready_o, rd_en_o, rd_idx_o, alu_data1_o, alu_data2_o,
               alu_ctrl_o, wb_valid_o, wb_idx_o, wb_data_o, done_o, zero_mask_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_vl_i, rd_data1_i, rd_data2_i,
               alu_result_i, alu_zero_i, wb_ready_i,
        input  cmd_ready_o, rd_en_o, rd_idx_o, alu_data1_o, alu_data2_o,
               alu_ctrl_o, wb_valid_o, wb_idx_o, wb_data_o, done_o, zero_mask_o
    );
endinterface

// File: rtl/alu_vec_sequencer.sv
// Element-serial vector ALU sequencer. It steps one vector command through
// the shared scalar ALU one element at a time.
// Each element takes the path FETCH (register-file read), EXEC (ALU) and
// WB (write-back handshake). A per-element zero mask is collected on the way.
module alu_vec_sequencer #(
    parameter int NUM_ELEM = 8,
    parameter int IDXW     = 3,
    parameter int DW       = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_vec_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [IDXW:0] VL_MAX = (IDXW + 1)'(NUM_ELEM);
    localparam logic [IDXW:0] ONE    = (IDXW + 1)'(1);

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [IDXW:0]       vl_q, vl_d;
    logic [IDXW:0]       cnt_q, cnt_d;
    logic [IDXW-1:0]     wb_idx_q, wb_idx_d;
    logic [DW-1:0]       wb_data_q, wb_data_d;
    logic [NUM_ELEM-1:0] mask_q, mask_d;
    logic [IDXW:0]       vl_clamped;

    assign vl_clamped = (bus.cmd_vl_i > VL_MAX) ? VL_MAX : bus.cmd_vl_i;

    assign bus.cmd_ready_o = (state_q == S_IDLE) && !rst_i;
    assign bus.rd_en_o     = (state_q == S_FETCH);
    assign bus.rd_idx_o    = cnt_q[IDXW-1:0];
    assign bus.alu_data1_o = (state_q == S_EXEC) ? bus.rd_data1_i : '0;
    assign bus.alu_data2_o = (state_q == S_EXEC) ? bus.rd_data2_i : '0;
    assign bus.alu_ctrl_o  = op_q;
    assign bus.wb_valid_o  = (state_q == S_WB);
    assign bus.wb_idx_o    = wb_idx_q;
    assign bus.wb_data_o   = wb_data_q;
    assign bus.done_o      = (state_q == S_DONE);
    assign bus.zero_mask_o = mask_q;

    // Next-state and datapath update: accept a command, walk the elements, capture results
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        vl_d      = vl_q;
        cnt_d     = cnt_q;
        wb_idx_d  = wb_idx_q;
        wb_data_d = wb_data_q;
        mask_d    = mask_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    op_d    = bus.cmd_op_i;
                    vl_d    = vl_clamped;
                    cnt_d   = '0;
                    mask_d  = '0;
                    state_d = (vl_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                wb_data_d                 = bus.alu_result_i;
                wb_idx_d                  = cnt_q[IDXW-1:0];
                mask_d[cnt_q[IDXW-1:0]]   = bus.alu_zero_i;
                state_d                   = S_WB;
            end
            S_WB: begin
                if (bus.wb_ready_i) begin
                    if (cnt_q == vl_q - ONE) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + ONE;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any command in flight and clears all results
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            vl_q      <= '0;
            cnt_q     <= '0;
            wb_idx_q  <= '0;
            wb_data_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            vl_q      <= vl_d;
            cnt_q     <= cnt_d;
            wb_idx_q  <= wb_idx_d;
            wb_data_q <= wb_data_d;
            mask_q    <= mask_d;
        end
    end
endmodule

// File: tb/tb_alu_vec_sequencer.sv
// Directed testbench for alu_vec_sequencer. It provides a register-file model
// with one-cycle read latency and a combinational scalar ALU model.
module tb_alu_vec_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] rf1 [8];
    logic [31:0] rf2 [8];

    int          obs_n_wb, obs_n_rd, obs_done_rel, obs_stall_changes, obs_ctrl_bad, obs_ready_busy;
    logic        obs_ready_after;
    logic [7:0]  obs_mask, obs_mask_after;
    logic [31:0] obs_data [16];
    logic [2:0]  obs_idx [16];
    logic [2:0]  obs_rd_idx [16];

    alu_vec_sequencer_if #(.NUM_ELEM(8), .IDXW(3), .DW(32)) bus ();

    alu_vec_sequencer #(.NUM_ELEM(8), .IDXW(3), .DW(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: operands appear the cycle after the read strobe
    always @(posedge clk) begin
        if (bus.rd_en_o) begin
            bus.rd_data1_i <= rf1[bus.rd_idx_o];
            bus.rd_data2_i <= rf2[bus.rd_idx_o];
        end
    end

    // Scalar ALU: combinational result and equality flag
    always_comb begin
        bus.alu_result_i = '0;
        case (bus.alu_ctrl_o)
            3'b001: bus.alu_result_i = bus.alu_data1_o + bus.alu_data2_o;
            3'b010: bus.alu_result_i = bus.alu_data1_o - bus.alu_data2_o;
            3'b011: bus.alu_result_i = bus.alu_data1_o & bus.alu_data2_o;
            3'b100: bus.alu_result_i = bus.alu_data1_o | bus.alu_data2_o;
            3'b101: bus.alu_result_i = bus.alu_data1_o ^ bus.alu_data2_o;
            3'b110: bus.alu_result_i = bus.alu_data1_o * bus.alu_data2_o;
            default: bus.alu_result_i = '0;
        endcase
        bus.alu_zero_i = (bus.alu_data1_o == bus.alu_data2_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command in the current IDLE cycle and records everything observed
    // until one cycle after done_o. Stall cycles are given relative to the accept cycle.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] vl,
                           input int stall_from, input int stall_len, input bit hold_valid);
        logic        prev_stalled;
        logic [31:0] prev_data;
        logic [2:0]  prev_idx;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_vl_i    = vl;
        bus.wb_ready_i  = 1'b1;
        tick();
        obs_n_wb = 0; obs_n_rd = 0; obs_done_rel = -1; obs_stall_changes = 0;
        obs_ctrl_bad = 0; obs_ready_busy = 0; obs_ready_after = 1'b0;
        obs_mask = 8'hxx; obs_mask_after = 8'hxx;
        prev_stalled = 1'b0; prev_data = '0; prev_idx = '0;
        if (!hold_valid) bus.cmd_valid_i = 1'b0;
        for (int rel = 1; rel <= 200; rel++) begin
            if (hold_valid) bus.cmd_op_i = 3'(rel);
            bus.wb_ready_i = !(rel >= stall_from && rel < stall_from + stall_len);
            if (bus.alu_ctrl_o !== op) obs_ctrl_bad++;
            if (bus.rd_en_o === 1'b1) begin
                if (obs_n_rd < 16) obs_rd_idx[obs_n_rd] = bus.rd_idx_o;
                obs_n_rd++;
            end
            if (prev_stalled && bus.wb_valid_o === 1'b1 &&
                (bus.wb_data_o !== prev_data || bus.wb_idx_o !== prev_idx))
                obs_stall_changes++;
            if (bus.wb_valid_o === 1'b1 && bus.wb_ready_i) begin
                if (obs_n_wb < 16) begin
                    obs_data[obs_n_wb] = bus.wb_data_o;
                    obs_idx[obs_n_wb]  = bus.wb_idx_o;
                end
                obs_n_wb++;
            end
            prev_stalled = (bus.wb_valid_o === 1'b1) && !bus.wb_ready_i;
            prev_data    = bus.wb_data_o;
            prev_idx     = bus.wb_idx_o;
            if (bus.done_o === 1'b1) begin
                obs_done_rel    = rel;
                obs_mask        = bus.zero_mask_o;
                bus.cmd_valid_i = 1'b0;
            end else if (bus.cmd_ready_o === 1'b1) begin
                obs_ready_busy++;
            end
            tick();
            if (obs_done_rel > 0) begin
                obs_ready_after = bus.cmd_ready_o;
                obs_mask_after  = bus.zero_mask_o;
                break;
            end
        end
        bus.cmd_valid_i = 1'b0;
        bus.wb_ready_i  = 1'b1;
    endtask

    // Reset values while rst is held, then ready as soon as it drops
    task automatic test_reset();
        checks++; if (bus.cmd_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 0", bus.cmd_ready_o); end
        checks++; if (bus.rd_en_o !== 1'b0 || bus.wb_valid_o !== 1'b0 || bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes: got rd=%0b wb=%0b done=%0b expected 0", bus.rd_en_o, bus.wb_valid_o, bus.done_o); end
        checks++; if (bus.wb_data_o !== 32'h0 || bus.wb_idx_o !== 3'h0 || bus.zero_mask_o !== 8'h0 || bus.alu_ctrl_o !== 3'h0) begin errors++; $display("[TB] FAIL reset_regs: got data=%0h idx=%0h mask=%0h ctrl=%0h expected 0", bus.wb_data_o, bus.wb_idx_o, bus.zero_mask_o, bus.alu_ctrl_o); end
        checks++; if (bus.alu_data1_o !== 32'h0 || bus.alu_data2_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_alu_data: got %0h %0h expected 0", bus.alu_data1_o, bus.alu_data2_o); end
        rst = 1'b0;
        #1;
        checks++; if (bus.cmd_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %0b expected 1", bus.cmd_ready_o); end
        tick();
    endtask

    // SUM over four elements, no backpressure
    task automatic test_sum();
        logic [31:0] exp_d [4] = '{32'd1, 32'd12, 32'd23, 32'd34};
        for (int i = 0; i < 8; i++) begin rf1[i] = 32'(i + 1); rf2[i] = 32'(10 * i); end
        run_cmd(3'b001, 4'd4, 0, 0, 1'b0);
        checks++; if (obs_n_wb !== 4) begin errors++; $display("[TB] FAIL sum_count: got %0d expected 4", obs_n_wb); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_data[i] !== exp_d[i] || obs_idx[i] !== 3'(i)) begin errors++; $display("[TB] FAIL sum_elem%0d: got data=%0d idx=%0d expected data=%0d idx=%0d", i, obs_data[i], obs_idx[i], exp_d[i], i); end
        end
        checks++; if (obs_done_rel !== 13) begin errors++; $display("[TB] FAIL sum_done_cycle: got %0d expected 13", obs_done_rel); end
        checks++; if (obs_mask !== 8'h00) begin errors++; $display("[TB] FAIL sum_mask: got %0h expected 00", obs_mask); end
        checks++; if (obs_ready_after !== 1'b1) begin errors++; $display("[TB] FAIL sum_ready_after: got %0b expected 1", obs_ready_after); end
        checks++; if (obs_ctrl_bad !== 0) begin errors++; $display("[TB] FAIL sum_ctrl: got %0d bad cycles expected 0", obs_ctrl_bad); end
    endtask

    // SUB with equal pairs setting mask bits
    task automatic test_sub();
        logic [31:0] exp_d [3] = '{32'd0, 32'd5, 32'd0};
        rf1[0] = 32'd5; rf2[0] = 32'd5;
        rf1[1] = 32'd7; rf2[1] = 32'd2;
        rf1[2] = 32'd9; rf2[2] = 32'd9;
        run_cmd(3'b010, 4'd3, 0, 0, 1'b0);
        checks++; if (obs_n_wb !== 3) begin errors++; $display("[TB] FAIL sub_count: got %0d expected 3", obs_n_wb); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_data[i] !== exp_d[i] || obs_idx[i] !== 3'(i)) begin errors++; $display("[TB] FAIL sub_elem%0d: got data=%0d idx=%0d expected data=%0d idx=%0d", i, obs_data[i], obs_idx[i], exp_d[i], i); end
        end
        checks++; if (obs_mask !== 8'b0000_0101) begin errors++; $display("[TB] FAIL sub_mask: got %b expected 00000101", obs_mask); end
        checks++; if (obs_mask_after !== 8'b0000_0101) begin errors++; $display("[TB] FAIL sub_mask_hold: got %b expected 00000101", obs_mask_after); end
        checks++; if (obs_done_rel !== 10) begin errors++; $display("[TB] FAIL sub_done_cycle: got %0d expected 10", obs_done_rel); end
    endtask

    // MUL with write-back held off: ready low from accept+2 to accept+6, four of those in WB
    task automatic test_mul_stall();
        rf1[0] = 32'h0001_0000; rf2[0] = 32'h0001_0000;
        rf1[1] = 32'd3;         rf2[1] = 32'd4;
        run_cmd(3'b110, 4'd2, 2, 5, 1'b0);
        checks++; if (obs_n_wb !== 2) begin errors++; $display("[TB] FAIL mul_count: got %0d expected 2", obs_n_wb); end
        checks++; if (obs_data[0] !== 32'h0 || obs_idx[0] !== 3'd0) begin errors++; $display("[TB] FAIL mul_elem0: got data=%0h idx=%0d expected data=0 idx=0", obs_data[0], obs_idx[0]); end
        checks++; if (obs_data[1] !== 32'd12 || obs_idx[1] !== 3'd1) begin errors++; $display("[TB] FAIL mul_elem1: got data=%0d idx=%0d expected data=12 idx=1", obs_data[1], obs_idx[1]); end
        checks++; if (obs_stall_changes !== 0) begin errors++; $display("[TB] FAIL mul_stall_stable: got %0d changes expected 0", obs_stall_changes); end
        checks++; if (obs_done_rel !== 11) begin errors++; $display("[TB] FAIL mul_done_cycle: got %0d expected 11", obs_done_rel); end
        checks++; if (obs_mask !== 8'b0000_0001) begin errors++; $display("[TB] FAIL mul_mask: got %b expected 00000001", obs_mask); end
    endtask

    // Zero-length command and an over-length command that clamps to eight elements
    task automatic test_vl_bounds();
        run_cmd(3'b101, 4'd0, 0, 0, 1'b0);
        checks++; if (obs_done_rel !== 1) begin errors++; $display("[TB] FAIL vl0_done_cycle: got %0d expected 1", obs_done_rel); end
        checks++; if (obs_n_rd !== 0 || obs_n_wb !== 0) begin errors++; $display("[TB] FAIL vl0_activity: got rd=%0d wb=%0d expected 0 0", obs_n_rd, obs_n_wb); end
        checks++; if (obs_mask !== 8'h00) begin errors++; $display("[TB] FAIL vl0_mask: got %0h expected 00", obs_mask); end
        for (int i = 0; i < 8; i++) begin rf1[i] = 32'(i); rf2[i] = 32'(i); end
        run_cmd(3'b001, 4'd15, 0, 0, 1'b0);
        checks++; if (obs_n_wb !== 8 || obs_n_rd !== 8) begin errors++; $display("[TB] FAIL clamp_count: got wb=%0d rd=%0d expected 8 8", obs_n_wb, obs_n_rd); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (obs_data[i] !== 32'(2 * i) || obs_idx[i] !== 3'(i) || obs_rd_idx[i] !== 3'(i)) begin errors++; $display("[TB] FAIL clamp_elem%0d: got data=%0d idx=%0d rd_idx=%0d expected data=%0d idx=%0d", i, obs_data[i], obs_idx[i], obs_rd_idx[i], 2 * i, i); end
        end
        checks++; if (obs_done_rel !== 25) begin errors++; $display("[TB] FAIL clamp_done_cycle: got %0d expected 25", obs_done_rel); end
        checks++; if (obs_mask !== 8'hFF) begin errors++; $display("[TB] FAIL clamp_mask: got %0h expected ff", obs_mask); end
        checks++; if (obs_ready_after !== 1'b1) begin errors++; $display("[TB] FAIL clamp_ready_after: got %0b expected 1", obs_ready_after); end
    endtask

    // Reset in the third element's EXEC of an AND command, then a fresh OR command
    task automatic test_reset_abort();
        int late_events;
        for (int i = 0; i < 8; i++) begin rf1[i] = 32'(i + 100); rf2[i] = 32'(i); end
        rf1[0] = 32'd5; rf2[0] = 32'd5;
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 3'b011; bus.cmd_vl_i = 4'd8; bus.wb_ready_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        repeat (7) tick();
        checks++; if (bus.alu_data1_o !== 32'd102 || bus.zero_mask_o !== 8'b0000_0001) begin errors++; $display("[TB] FAIL abort_pre_state: got alu1=%0d mask=%b expected 102 00000001", bus.alu_data1_o, bus.zero_mask_o); end
        rst = 1'b1;
        tick();
        checks++; if (bus.rd_en_o !== 1'b0 || bus.wb_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.cmd_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_strobes: got rd=%0b wb=%0b done=%0b rdy=%0b expected 0", bus.rd_en_o, bus.wb_valid_o, bus.done_o, bus.cmd_ready_o); end
        checks++; if (bus.wb_data_o !== 32'h0 || bus.wb_idx_o !== 3'h0 || bus.zero_mask_o !== 8'h0 || bus.alu_ctrl_o !== 3'h0 || bus.alu_data1_o !== 32'h0 || bus.alu_data2_o !== 32'h0) begin errors++; $display("[TB] FAIL abort_regs: got data=%0h idx=%0h mask=%0h ctrl=%0h alu=%0h/%0h expected 0", bus.wb_data_o, bus.wb_idx_o, bus.zero_mask_o, bus.alu_ctrl_o, bus.alu_data1_o, bus.alu_data2_o); end
        rst = 1'b0;
        late_events = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.done_o !== 1'b0 || bus.wb_valid_o !== 1'b0) late_events++;
            tick();
        end
        checks++; if (late_events !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d events expected 0", late_events); end
        rf1[0] = 32'h0000_00F0; rf2[0] = 32'h0000_000F;
        run_cmd(3'b100, 4'd1, 0, 0, 1'b0);
        checks++; if (obs_n_wb !== 1 || obs_data[0] !== 32'hFF || obs_idx[0] !== 3'd0) begin errors++; $display("[TB] FAIL abort_or_result: got n=%0d data=%0h idx=%0d expected 1 ff 0", obs_n_wb, obs_data[0], obs_idx[0]); end
        checks++; if (obs_done_rel !== 4 || obs_mask !== 8'h00) begin errors++; $display("[TB] FAIL abort_or_done: got rel=%0d mask=%0h expected 4 00", obs_done_rel, obs_mask); end
    endtask

    // Command valid held with a changing op while busy: neither accepted nor applied
    task automatic test_back_to_back();
        rf1[0] = 32'hF0F0; rf2[0] = 32'hFF00;
        rf1[1] = 32'h1234; rf2[1] = 32'h00FF;
        run_cmd(3'b011, 4'd2, 0, 0, 1'b1);
        checks++; if (obs_ctrl_bad !== 0) begin errors++; $display("[TB] FAIL hold_ctrl: got %0d changed cycles expected 0", obs_ctrl_bad); end
        checks++; if (obs_ready_busy !== 0) begin errors++; $display("[TB] FAIL hold_ready_busy: got %0d cycles expected 0", obs_ready_busy); end
        checks++; if (obs_done_rel !== 7 || obs_n_wb !== 2) begin errors++; $display("[TB] FAIL hold_done: got rel=%0d n=%0d expected 7 2", obs_done_rel, obs_n_wb); end
        checks++; if (obs_data[0] !== 32'hF000 || obs_data[1] !== 32'h0034) begin errors++; $display("[TB] FAIL hold_data: got %0h %0h expected f000 34", obs_data[0], obs_data[1]); end
        run_cmd(3'b100, 4'd1, 0, 0, 1'b0);
        checks++; if (obs_ctrl_bad !== 0 || obs_data[0] !== 32'hFFF0) begin errors++; $display("[TB] FAIL next_cmd_ctrl: got bad=%0d data=%0h expected 0 fff0", obs_ctrl_bad, obs_data[0]); end
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    // Test sequence
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 3'b000;
        bus.cmd_vl_i    = 4'd0;
        bus.wb_ready_i  = 1'b1;
        for (int i = 0; i < 8; i++) begin rf1[i] = '0; rf2[i] = '0; end
        repeat (3) tick();
        test_reset();
        test_sum();
        test_sub();
        test_mul_stall();
        test_vl_bounds();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
